// File: rtl/myproject_acc_relu_13s_8s.sv
// myproject_acc_relu_13s_8s
//
// Accumulate/activation stage behind the 8s x 6s -> 13s product multipliers of
// the quantized LeNet-5 datapath. Sums N_IN signed products (8 fractional bits)
// together with a per-neuron bias (4 fractional bits, aligned by BIAS_SHIFT).
// The sum is then rescaled to the 4-fractional-bit output format by an
// arithmetic right shift that floors. ReLU is optional, and the result
// saturates to OUT_W bits. It is presented on a valid/ready output.
//
// Ports:
//   ap_clk      in   clock, rising edge
//   ap_rst_n    in   synchronous active-low reset
//   prod_data   in   signed product (PROD_W)
//   prod_valid  in   prod_data valid
//   prod_ready  out  stage accepts a product this cycle (state decode only)
//   bias        in   signed bias (BIAS_W), sampled with the first product of a group
//   out_data    out  signed result (OUT_W)
//   out_valid   out  out_data valid
//   out_ready   in   downstream accepts out_data
//
// ACC_W must hold N_IN * 2^(PROD_W-1) + 2^(BIAS_W-1+BIAS_SHIFT) so the
// accumulator never wraps.

module myproject_acc_relu_13s_8s #(
  parameter int unsigned PROD_W     = 13,
  parameter int unsigned N_IN       = 25,
  parameter int unsigned ACC_W      = 18,
  parameter int unsigned BIAS_W     = 8,
  parameter int unsigned BIAS_SHIFT = 4,
  parameter int unsigned OUT_SHIFT  = 4,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned RELU       = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [BIAS_W-1:0] bias,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned CntW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N_IN - 1);

  // Saturation bounds expressed at accumulator width; min is ~max in two's complement.
  localparam logic signed [ACC_W-1:0] SatMax = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;

  typedef enum logic [0:0] {
    StAcc,
    StHold
  } state_e;

  state_e                   r_state;
  logic [CntW-1:0]          r_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic [OUT_W-1:0]         r_out_data;
  logic                     r_out_valid;

  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W-1:0]  w_base;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_shifted;
  logic signed [ACC_W-1:0]  w_act;
  logic [OUT_W-1:0]         w_sat;
  logic                     w_first;
  logic                     w_last;
  logic                     w_accept;

  assign prod_ready = (r_state == StAcc);
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;

  assign w_accept = prod_valid && prod_ready;
  assign w_first  = (r_cnt == '0);
  assign w_last   = (r_cnt == CntLast);

  assign w_prod_ext = ACC_W'($signed(prod_data));
  assign w_bias_ext = ACC_W'($signed(bias)) <<< BIAS_SHIFT;

  // The first product of a group starts from the bias instead of the running
  // sum. With N_IN == 1 the first product is also the last, so bias is still included.
  assign w_base = w_first ? w_bias_ext : r_acc;
  assign w_sum  = w_base + w_prod_ext;

  // Arithmetic shift floors toward -inf; no rounding by design.
  assign w_shifted = w_sum >>> OUT_SHIFT;

  always_comb begin
    w_act = w_shifted;
    if ((RELU != 0) && w_shifted[ACC_W-1]) begin
      w_act = '0;
    end
  end

  always_comb begin
    w_sat = w_act[OUT_W-1:0];
    if (w_act > SatMax) begin
      w_sat = SatMax[OUT_W-1:0];
    end else if (w_act < SatMin) begin
      w_sat = SatMin[OUT_W-1:0];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state     <= StAcc;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StAcc: begin
          if (w_accept) begin
            if (w_last) begin
              r_out_data  <= w_sat;
              r_out_valid <= 1'b1;
              r_cnt       <= '0;
              r_acc       <= '0;
              r_state     <= StHold;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StHold: begin
          // Output is frozen until the downstream handshake completes.
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StAcc;
          end
        end
        default: begin
          r_state <= StAcc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_acc_relu_13s_8s.sv
module tb_myproject_acc_relu_13s_8s;

  localparam int NIn = 25;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [12:0] prod_data = '0;
  logic        prod_valid = 1'b0;
  logic [7:0]  bias = '0;
  logic        out_ready = 1'b0;

  logic        rdy_r, vld_r, rdy_l, vld_l;
  logic [7:0]  dat_r, dat_l;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] e_relu;
    logic [7:0] e_lin;
  } exp_t;

  exp_t sb[$];
  logic signed [12:0] g_prod[NIn];

  always #5 ap_clk = ~ap_clk;

  myproject_acc_relu_13s_8s #(.RELU(1)) u_dut_relu (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .prod_data (prod_data),
    .prod_valid(prod_valid),
    .prod_ready(rdy_r),
    .bias      (bias),
    .out_data  (dat_r),
    .out_valid (vld_r),
    .out_ready (out_ready)
  );

  myproject_acc_relu_13s_8s #(.RELU(0)) u_dut_lin (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .prod_data (prod_data),
    .prod_valid(prod_valid),
    .prod_ready(rdy_l),
    .bias      (bias),
    .out_data  (dat_l),
    .out_valid (vld_l),
    .out_ready (out_ready)
  );

  // Reference: bias at product scale, floor shift by 4, optional ReLU, clamp.
  function automatic logic [7:0] model(input int sum_v, input bit relu);
    int v;
    v = sum_v >>> 4;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < NIn; i++) g_prod[i] = 13'(v);
  endtask

  // Drives n products from g_prod; pushes the expected result when a full group is sent.
  task automatic send_group(input int bias_v, input int gap_pct, input bit jitter,
                            input int n, input bit push);
    int sum_v;
    int t;
    exp_t e;
    if (push) begin
      sum_v = bias_v * 16;
      for (int i = 0; i < NIn; i++) sum_v += int'(g_prod[i]);
      e.e_relu = model(sum_v, 1'b1);
      e.e_lin  = model(sum_v, 1'b0);
      sb.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct && t < 8) begin
        prod_valid = 1'b0;
        prod_data  = 13'($urandom);
        bias       = 8'($urandom);
        tick();
        t++;
      end
      prod_valid = 1'b1;
      prod_data  = g_prod[i];
      bias       = (i == 0 || !jitter) ? bias_v[7:0] : 8'($urandom);
      t = 0;
      while (!rdy_r && t < 100) begin
        tick();
        t++;
      end
      if (t >= 100) begin
        errors++;
        $display("FAIL accept_timeout prod_ready=%0b required 1", rdy_r);
      end
      if (push && i == n - 1) begin
        checks++;
        if (vld_r !== 1'b0 || vld_l !== 1'b0) begin
          errors++;
          $display("FAIL early_valid got %0b/%0b required 0/0", vld_r, vld_l);
        end
      end
      tick();
    end
    prod_valid = 1'b0;
  endtask

  // Waits for the result, stalls for `stall` cycles, then completes the handshake.
  task automatic collect(input int stall);
    int t;
    logic [7:0] snap_r, snap_l;
    exp_t e;
    t = 0;
    while (!vld_r && t < 100) begin
      tick();
      t++;
    end
    checks++;
    if (vld_r !== 1'b1 || vld_l !== 1'b1) begin
      errors++;
      $display("FAIL out_valid_wait got %0b/%0b required 1/1", vld_r, vld_l);
    end
    snap_r = dat_r;
    snap_l = dat_l;
    for (int i = 0; i < stall; i++) begin
      prod_valid = 1'b1;
      prod_data  = 13'd1000;
      tick();
      checks++;
      if (dat_r !== snap_r || dat_l !== snap_l || vld_r !== 1'b1 || rdy_r !== 1'b0
          || rdy_l !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable data=%h/%h valid=%0b ready=%0b required %h/%h 1 0",
                 dat_r, dat_l, vld_r, rdy_r, snap_r, snap_l);
      end
    end
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got output %h required none", dat_r);
    end else begin
      e = sb.pop_front();
      if (dat_r !== e.e_relu || dat_l !== e.e_lin) begin
        errors++;
        $display("FAIL out_data got %h/%h required %h/%h", dat_r, dat_l, e.e_relu, e.e_lin);
      end
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (vld_r !== 1'b0 || vld_l !== 1'b0 || rdy_r !== 1'b1 || rdy_l !== 1'b1) begin
      errors++;
      $display("FAIL post_handshake valid=%0b/%0b ready=%0b/%0b required 0/0 1/1",
               vld_r, vld_l, rdy_r, rdy_l);
    end
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (rdy_r !== 1'b1 || rdy_l !== 1'b1 || vld_r !== 1'b0 || vld_l !== 1'b0
        || dat_r !== 8'h00 || dat_l !== 8'h00) begin
      errors++;
      $display("FAIL %s ready=%0b/%0b valid=%0b/%0b data=%h/%h required 1/1 0/0 00/00",
               tag, rdy_r, rdy_l, vld_r, vld_l, dat_r, dat_l);
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    tick();
    tick();
    check_reset_state("reset_state");
    ap_rst_n = 1'b1;
    tick();
    check_reset_state("idle_after_reset");
  endtask

  task automatic test_basic();
    fill(16);
    send_group(0, 0, 1'b0, NIn, 1'b1);
    checks++;
    if (vld_r !== 1'b1 || rdy_r !== 1'b0) begin
      errors++;
      $display("FAIL latency valid=%0b ready=%0b required 1 0", vld_r, rdy_r);
    end
    collect(0);
  endtask

  task automatic test_bias_gaps();
    fill(0);
    send_group(16, 40, 1'b1, NIn, 1'b1);
    collect(0);
  endtask

  task automatic test_saturation();
    fill(4095);
    send_group(0, 0, 1'b0, NIn, 1'b1);
    collect(0);
    fill(-4096);
    send_group(0, 0, 1'b0, NIn, 1'b1);
    collect(0);
  endtask

  task automatic test_floor();
    fill(0);
    g_prod[0] = -13'sd1;
    send_group(0, 0, 1'b0, NIn, 1'b1);
    collect(0);
    fill(0);
    g_prod[7] = 13'sd15;
    send_group(0, 0, 1'b0, NIn, 1'b1);
    collect(0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < NIn; i++) g_prod[i] = 13'(i * 37 - 400);
    send_group(-5, 0, 1'b0, NIn, 1'b1);
    collect(5);
    fill(16);
    send_group(3, 0, 1'b0, NIn, 1'b1);
    collect(2);
  endtask

  task automatic test_reset_mid_group();
    fill(100);
    send_group(20, 0, 1'b0, 10, 1'b0);
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    check_reset_state("reset_mid_group");
    fill(16);
    send_group(0, 0, 1'b0, NIn, 1'b1);
    collect(0);
  endtask

  task automatic test_random();
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < NIn; i++) g_prod[i] = 13'($urandom);
      send_group($urandom_range(255) - 128, 20, 1'b1, NIn, 1'b1);
      collect(int'($urandom_range(3)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias_gaps();
    test_saturation();
    test_floor();
    test_backpressure();
    test_reset_mid_group();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
